// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM hazard sources in, stage-register controls out.
interface hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_branch;
    logic             id_branch_taken;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [1:0]       ex_reg_dst;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_rd;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic             mem_reg_write;
    logic [REG_W-1:0] mem_dst;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             idex_bubble;
    logic             memwb_bubble;
    logic             ifid_flush;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
               ex_mem_read, ex_reg_write, ex_reg_dst, ex_rt, ex_rd,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_dst, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               idex_bubble, memwb_bubble, ifid_flush, mem_timeout_err, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
               ex_mem_read, ex_reg_write, ex_reg_dst, ex_rt, ex_rd,
               mem_mem_read, mem_mem_write, mem_reg_write, mem_dst, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               idex_bubble, memwb_bubble, ifid_flush, mem_timeout_err, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage MIPS pipeline: load-use / branch-in-ID stalls,
// data-memory wait freeze with timeout, taken-branch flush and a stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [REG_W-1:0]  ex_dst;
    logic              ex_dst_ok, hit_ex, hit_mem;
    logic              lu, br, mem_acc, blocked, timeout, mw;
    logic              pc_write_c, ifid_write_c, idex_write_c, exmem_write_c;
    logic              idex_bubble_c, memwb_bubble_c, ifid_flush_c;

    // Hazard detection, stage controls and next-state
    always_comb begin
        ex_dst         = bus.ex_rt;
        pc_write_c     = 1'b1;
        ifid_write_c   = 1'b1;
        idex_write_c   = 1'b1;
        exmem_write_c  = 1'b1;
        idex_bubble_c  = 1'b0;
        memwb_bubble_c = 1'b0;
        ifid_flush_c   = 1'b0;
        state_d        = state_q;
        wait_cnt_d     = '0;
        err_d          = err_q;
        stall_cnt_d    = stall_cnt_q;

        case (bus.ex_reg_dst)
            2'b01:   ex_dst = bus.ex_rd;
            2'b10:   ex_dst = REG_W'(31);
            default: ex_dst = bus.ex_rt;
        endcase
        ex_dst_ok = (bus.ex_reg_dst != 2'b11) && (ex_dst != '0);
        hit_ex    = ex_dst_ok &&
                    ((bus.id_uses_rs && (bus.id_rs == ex_dst)) ||
                     (bus.id_uses_rt && (bus.id_rt == ex_dst)));
        hit_mem   = (bus.mem_dst != '0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.mem_dst)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.mem_dst)));

        lu      = bus.ex_mem_read && bus.ex_reg_write && hit_ex;
        br      = bus.id_is_branch &&
                  ((bus.ex_reg_write && hit_ex) ||
                   (bus.mem_mem_read && bus.mem_reg_write && hit_mem));
        mem_acc = bus.mem_mem_read || bus.mem_mem_write;
        blocked = mem_acc && !bus.dmem_ready;
        timeout = (state_q == ST_WAIT) && (wait_cnt_q == WCNT_W'(MEM_TIMEOUT));
        mw      = blocked && !timeout;

        if (!reset) begin
            if (mw) begin
                pc_write_c     = 1'b0;
                ifid_write_c   = 1'b0;
                idex_write_c   = 1'b0;
                exmem_write_c  = 1'b0;
                memwb_bubble_c = 1'b1;
            end else if (lu || br) begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_bubble_c = 1'b1;
            end else if (bus.id_branch_taken) begin
                ifid_flush_c = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (blocked) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!blocked || timeout) state_d = ST_RUN;
                else                     wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                // A timeout that lands on the ready cycle is a completed access, not an error
                if (blocked && timeout) err_d = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        if (!pc_write_c && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State, wait counter, sticky error and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_write        = pc_write_c;
    assign bus.ifid_write      = ifid_write_c;
    assign bus.idex_write      = idex_write_c;
    assign bus.exmem_write     = exmem_write_c;
    assign bus.idex_bubble     = idex_bubble_c;
    assign bus.memwb_bubble    = memwb_bubble_c;
    assign bus.ifid_flush      = ifid_flush_c;
    assign bus.mem_timeout_err = err_q && !reset;
    assign bus.stall_count     = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a per-cycle reference model and literal checkpoints.
module tb_hazard_ctrl;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 4;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: streak of consecutive frozen memory cycles, sticky error, stall total
    int m_streak = 0;
    bit m_err    = 1'b0;
    int m_stall  = 0;

    function automatic int ex_dst_m();
        int d;
        case (bus.ex_reg_dst)
            2'd0:    d = int'(bus.ex_rt);
            2'd1:    d = int'(bus.ex_rd);
            2'd2:    d = 31;
            default: d = -1;
        endcase
        return (d == 0) ? -1 : d;
    endfunction

    function automatic bit hit_m(input int d);
        return (d > 0) && ((bus.id_uses_rs && int'(bus.id_rs) == d) ||
                           (bus.id_uses_rt && int'(bus.id_rt) == d));
    endfunction

    always @(negedge clk) begin
        bit lu, br, blocked, frz;
        bit e_pc, e_ifid, e_idex, e_exmem, e_idb, e_mwb, e_fl;
        lu      = bus.ex_mem_read && bus.ex_reg_write && hit_m(ex_dst_m());
        br      = bus.id_is_branch &&
                  ((bus.ex_reg_write && hit_m(ex_dst_m())) ||
                   (bus.mem_mem_read && bus.mem_reg_write && hit_m(int'(bus.mem_dst))));
        blocked = (bus.mem_mem_read || bus.mem_mem_write) && !bus.dmem_ready;
        frz     = blocked && (m_streak <= int'(TMO));
        {e_pc, e_ifid, e_idex, e_exmem, e_idb, e_mwb, e_fl} = 7'b1111000;
        if (!reset) begin
            if (frz) {e_pc, e_ifid, e_idex, e_exmem, e_mwb} = 5'b00001;
            else if (lu || br) {e_pc, e_ifid, e_idb} = 3'b001;
            else if (bus.id_branch_taken) e_fl = 1'b1;
        end
        chk("m_pc_write",     32'(bus.pc_write),        32'(e_pc));
        chk("m_ifid_write",   32'(bus.ifid_write),      32'(e_ifid));
        chk("m_idex_write",   32'(bus.idex_write),      32'(e_idex));
        chk("m_exmem_write",  32'(bus.exmem_write),     32'(e_exmem));
        chk("m_idex_bubble",  32'(bus.idex_bubble),     32'(e_idb));
        chk("m_memwb_bubble", 32'(bus.memwb_bubble),    32'(e_mwb));
        chk("m_ifid_flush",   32'(bus.ifid_flush),      32'(e_fl));
        chk("m_timeout_err",  32'(bus.mem_timeout_err), 32'(m_err && !reset));
        chk("m_stall_count",  32'(bus.stall_count),     32'(m_stall));
        if (reset) begin
            m_streak = 0;
            m_err    = 1'b0;
            m_stall  = 0;
        end else begin
            if (frz) m_streak++;
            else begin
                if (blocked) m_err = 1'b1;
                m_streak = 0;
            end
            if (!e_pc && m_stall < SAT) m_stall++;
        end
    end

    task automatic idle();
        bus.id_rs = '0;  bus.id_rt = '0;
        bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
        bus.id_is_branch = 1'b0;  bus.id_branch_taken = 1'b0;
        bus.ex_mem_read = 1'b0;  bus.ex_reg_write = 1'b0;  bus.ex_reg_dst = 2'b11;
        bus.ex_rt = '0;  bus.ex_rd = '0;
        bus.mem_mem_read = 1'b0;  bus.mem_mem_write = 1'b0;  bus.mem_reg_write = 1'b0;
        bus.mem_dst = '0;  bus.dmem_ready = 1'b1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic id_src(input int rs, input int rt, input bit branch);
        bus.id_rs = REG_W'(rs);  bus.id_rt = REG_W'(rt);
        bus.id_uses_rs = 1'b1;  bus.id_uses_rt = 1'b1;
        bus.id_is_branch = branch;
    endtask

    task automatic ex_load(input int rt);
        bus.ex_mem_read = 1'b1;  bus.ex_reg_write = 1'b1;
        bus.ex_reg_dst = 2'b00;  bus.ex_rt = REG_W'(rt);
    endtask

    task automatic timeout_run(input string tag);
        idle();
        bus.mem_mem_read = 1'b1;  bus.mem_reg_write = 1'b1;
        bus.mem_dst = REG_W'(3);  bus.dmem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk({tag, "_pc"}, 32'(bus.pc_write), (i < 5) ? 32'd0 : 32'd1);
            next();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        next(); next();
        @(negedge clk);
        chk("rst_pc", 32'(bus.pc_write), 32'd1);
        chk("rst_stall", 32'(bus.stall_count), 32'd0);
        chk("rst_err", 32'(bus.mem_timeout_err), 32'd0);
        next();
        reset = 1'b0;

        // lw $2 in EX, add $3,$2,$4 in ID
        ex_load(2);  id_src(2, 4, 1'b0);
        @(negedge clk);
        chk("lu_pc", 32'(bus.pc_write), 32'd0);
        chk("lu_bubble", 32'(bus.idex_bubble), 32'd1);
        next();
        idle();
        @(negedge clk);
        chk("lu_cnt", 32'(bus.stall_count), 32'd1);
        next();

        // same shape with ex_rt = 0 never stalls
        ex_load(0);  id_src(0, 4, 1'b0);
        @(negedge clk);
        chk("r0_pc", 32'(bus.pc_write), 32'd1);
        next();

        // addi $5 (rd path) then beq $5,$6
        idle();
        bus.ex_reg_write = 1'b1;  bus.ex_reg_dst = 2'b01;  bus.ex_rd = REG_W'(5);  bus.ex_rt = REG_W'(9);
        id_src(5, 6, 1'b1);
        @(negedge clk);
        chk("br_alu_pc", 32'(bus.pc_write), 32'd0);
        next();
        idle();
        @(negedge clk);
        chk("br_alu_cnt", 32'(bus.stall_count), 32'd2);
        next();

        // lw $5 then beq $5: stalls in EX and again in MEM
        ex_load(5);  id_src(5, 6, 1'b1);
        @(negedge clk);
        chk("br_ld_ex_pc", 32'(bus.pc_write), 32'd0);
        next();
        idle();  id_src(5, 6, 1'b1);
        bus.mem_mem_read = 1'b1;  bus.mem_reg_write = 1'b1;  bus.mem_dst = REG_W'(5);
        @(negedge clk);
        chk("br_ld_mem_pc", 32'(bus.pc_write), 32'd0);
        next();
        idle();  id_src(5, 6, 1'b1);
        @(negedge clk);
        chk("br_ld_done_pc", 32'(bus.pc_write), 32'd1);
        chk("br_ld_cnt", 32'(bus.stall_count), 32'd4);
        next();

        // sw in MEM waits 3 cycles
        idle();
        bus.mem_mem_write = 1'b1;  bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sw_exmem", 32'(bus.exmem_write), 32'd0);
            chk("sw_memwb", 32'(bus.memwb_bubble), 32'd1);
            next();
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk("sw_done_exmem", 32'(bus.exmem_write), 32'd1);
        next();
        idle();
        @(negedge clk);
        chk("sw_cnt", 32'(bus.stall_count), 32'd7);
        next();

        // dmem_ready stuck low: 5 frozen cycles, then release with sticky error
        timeout_run("tmo");
        idle();
        @(negedge clk);
        chk("tmo_err", 32'(bus.mem_timeout_err), 32'd1);
        chk("tmo_cnt", 32'(bus.stall_count), 32'd12);
        next();
        @(negedge clk);
        chk("tmo_err_sticky", 32'(bus.mem_timeout_err), 32'd1);
        next();

        // MW and LU together, then LU alone after the access completes
        idle();
        bus.mem_mem_read = 1'b1;  bus.dmem_ready = 1'b0;
        ex_load(7);  bus.id_rs = REG_W'(7);  bus.id_uses_rs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mwlu_idb", 32'(bus.idex_bubble), 32'd0);
            chk("mwlu_memwb", 32'(bus.memwb_bubble), 32'd1);
            next();
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk("mwlu_lu_idb", 32'(bus.idex_bubble), 32'd1);
        chk("mwlu_lu_pc", 32'(bus.pc_write), 32'd0);
        next();
        idle();
        @(negedge clk);
        chk("mwlu_cnt", 32'(bus.stall_count), 32'd15);
        next();

        // taken branch: flush alone, suppressed under a stall
        bus.id_is_branch = 1'b1;  bus.id_branch_taken = 1'b1;
        bus.id_rs = REG_W'(8);  bus.id_uses_rs = 1'b1;
        @(negedge clk);
        chk("flush", 32'(bus.ifid_flush), 32'd1);
        next();
        ex_load(8);
        @(negedge clk);
        chk("flush_supp", 32'(bus.ifid_flush), 32'd0);
        next();
        idle();
        @(negedge clk);
        chk("sat_cnt", 32'(bus.stall_count), 32'(SAT));
        next();

        // reset mid-WAIT, then a fresh full timeout
        bus.mem_mem_read = 1'b1;  bus.dmem_ready = 1'b0;
        next(); next();
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_pc", 32'(bus.pc_write), 32'd1);
        chk("rstw_memwb", 32'(bus.memwb_bubble), 32'd0);
        next();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rstw_cnt", 32'(bus.stall_count), 32'd0);
        chk("rstw_err", 32'(bus.mem_timeout_err), 32'd0);
        next();
        timeout_run("tmo2");
        idle();
        @(negedge clk);
        chk("tmo2_err", 32'(bus.mem_timeout_err), 32'd1);
        chk("tmo2_cnt", 32'(bus.stall_count), 32'd5);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
